// File: rtl/bfu_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly with valid/ready flow control and sticky overflow.
// Build option BFU_SAT_EN: overflowed components clamp instead of wrapping.
module bfu_pipe #(
   parameter int unsigned DW = 8,
   parameter int unsigned TW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] in1,
   input  logic [2*DW-1:0] in2,
   input  logic [2*TW-1:0] tf,
   input  logic            scale,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] out1,
   output logic [2*DW-1:0] out2,
   output logic            ovf,
   input  logic            clr_ovf
);
   localparam int unsigned PW = DW + TW;
   localparam int unsigned SW = DW + TW + 1;
   localparam int unsigned OW = DW + TW + 2;

   function automatic logic out_of_range(input logic signed [OW-1:0] v);
      return !((&v[OW-1:DW-1]) || !(|v[OW-1:DW-1]));
   endfunction

   function automatic logic [DW-1:0] fit(input logic signed [OW-1:0] v);
      logic [DW-1:0] res;
      res = v[DW-1:0];
      if (out_of_range(v)) begin
`ifdef BFU_SAT_EN
         res = v[OW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
         res = v[DW-1:0];
`endif
      end
      return res;
   endfunction

   logic w_en;

   logic signed [DW-1:0] w_i2r, w_i2i;
   logic signed [TW-1:0] w_twr, w_twi;
   logic signed [PW-1:0] w_pr, w_pi, w_qr, w_qi;

   logic            r_s1_vld, r_s1_scale;
   logic [2*DW-1:0] r_s1_a;
   logic signed [PW-1:0] r_pr, r_pi, r_qr, r_qi;

   logic signed [DW-1:0] w_ar, w_ai;
   logic signed [SW-1:0] w_t1r, w_t1i, w_t2r, w_t2i;

   logic r_s2_vld, r_s2_scale;
   logic signed [SW-1:0] r_t1r, r_t1i, r_t2r, r_t2i;

   logic signed [OW-1:0] w_o1r, w_o1i, w_o2r, w_o2i;
   logic signed [OW-1:0] w_s1r, w_s1i, w_s2r, w_s2i;
   logic w_ovf_new;

   logic            r_out_vld, r_ovf;
   logic [2*DW-1:0] r_out1, r_out2;

   // Single global enable: every stage advances together, bubbles are kept.
   assign w_en     = ~r_out_vld | out_ready;
   assign in_ready = w_en;

   assign w_i2r = in2[2*DW-1:DW];
   assign w_i2i = in2[DW-1:0];
   assign w_twr = tf[2*TW-1:TW];
   assign w_twi = tf[TW-1:0];

   assign w_pr = PW'(w_i2r) * PW'(w_twr);
   assign w_pi = PW'(w_i2i) * PW'(w_twi);
   assign w_qr = PW'(w_i2r) * PW'(w_twi);
   assign w_qi = PW'(w_i2i) * PW'(w_twr);

   assign w_ar  = r_s1_a[2*DW-1:DW];
   assign w_ai  = r_s1_a[DW-1:0];
   assign w_t2r = SW'(r_pr) - SW'(r_pi);
   assign w_t2i = SW'(r_qr) + SW'(r_qi);
   // Align in1 with the Q1.(TW-1) product scale.
   assign w_t1r = SW'(w_ar) <<< (TW - 1);
   assign w_t1i = SW'(w_ai) <<< (TW - 1);

   assign w_o1r = OW'(r_t1r) + OW'(r_t2r);
   assign w_o1i = OW'(r_t1i) + OW'(r_t2i);
   assign w_o2r = OW'(r_t1r) - OW'(r_t2r);
   assign w_o2i = OW'(r_t1i) - OW'(r_t2i);

   assign w_s1r = r_s2_scale ? (w_o1r >>> TW) : (w_o1r >>> (TW - 1));
   assign w_s1i = r_s2_scale ? (w_o1i >>> TW) : (w_o1i >>> (TW - 1));
   assign w_s2r = r_s2_scale ? (w_o2r >>> TW) : (w_o2r >>> (TW - 1));
   assign w_s2i = r_s2_scale ? (w_o2i >>> TW) : (w_o2i >>> (TW - 1));

   assign w_ovf_new = r_s2_vld & (out_of_range(w_s1r) | out_of_range(w_s1i) |
                                  out_of_range(w_s2r) | out_of_range(w_s2i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_scale <= 1'b0;
         r_s1_a     <= '0;
         r_pr       <= '0;
         r_pi       <= '0;
         r_qr       <= '0;
         r_qi       <= '0;
         r_s2_vld   <= 1'b0;
         r_s2_scale <= 1'b0;
         r_t1r      <= '0;
         r_t1i      <= '0;
         r_t2r      <= '0;
         r_t2i      <= '0;
         r_out_vld  <= 1'b0;
         r_out1     <= '0;
         r_out2     <= '0;
      end else if (w_en) begin
         r_s1_vld   <= in_valid;
         r_s1_scale <= scale;
         r_s1_a     <= in1;
         r_pr       <= w_pr;
         r_pi       <= w_pi;
         r_qr       <= w_qr;
         r_qi       <= w_qi;
         r_s2_vld   <= r_s1_vld;
         r_s2_scale <= r_s1_scale;
         r_t1r      <= w_t1r;
         r_t1i      <= w_t1i;
         r_t2r      <= w_t2r;
         r_t2i      <= w_t2i;
         r_out_vld  <= r_s2_vld;
         r_out1     <= {fit(w_s1r), fit(w_s1i)};
         r_out2     <= {fit(w_s2r), fit(w_s2i)};
      end
   end

   // A new overflow takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_en && w_ovf_new) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign out_valid = r_out_vld;
   assign out1      = r_out1;
   assign out2      = r_out2;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_bfu_pipe.sv
// Scoreboard bench for bfu_pipe (DW=TW=8): directed vectors queued at issue, checked by a monitor.
module tb_bfu_pipe;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in1 = '0;
   logic [15:0] in2 = '0;
   logic [15:0] tf = '0;
   logic        scale = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out1;
   logic [15:0] out2;
   logic        ovf;
   logic        clr_ovf = 1'b0;

   typedef struct packed {
      logic [15:0] o1;
      logic [15:0] o2;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          rnd_en = 1'b0;
   bit          hold_v = 1'b0;
   logic [15:0] hold_o1, hold_o2;
   logic [7:0]  e2_re, e3_re;

   always #5 clk = ~clk;

   bfu_pipe #(.DW(DW), .TW(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .tf        (tf),
      .scale     (scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
      .out2      (out2),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf)
   );

   function automatic logic [15:0] pk(int re, int im);
      return {8'(re), 8'(im)};
   endfunction

   function automatic logic [7:0] fitm(int v);
      if (v > 127 || v < -128) begin
`ifdef BFU_SAT_EN
         return (v > 127) ? 8'h7f : 8'h80;
`else
         return 8'(v);
`endif
      end
      return 8'(v);
   endfunction

   // Reference butterfly in plain integer arithmetic.
   function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi, logic sc);
      int pr, pim, sh;
      int o1r, o1i, o2r, o2i;
      pr  = br * wr - bi * wi;
      pim = br * wi + bi * wr;
      sh  = 7 + int'(sc);
      o1r = (ar * 128 + pr) >>> sh;
      o1i = (ai * 128 + pim) >>> sh;
      o2r = (ar * 128 - pr) >>> sh;
      o2i = (ai * 128 - pim) >>> sh;
      return {fitm(o1r), fitm(o1i), fitm(o2r), fitm(o2i)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic send(input int ar, input int ai, input int br, input int bi, input int wr,
                       input int wi, input logic sc, input logic [15:0] e1,
                       input logic [15:0] e2);
      int n;
      n = 0;
      @(negedge clk);
      in1 = pk(ar, ai);
      in2 = pk(br, bi);
      tf = pk(wr, wi);
      scale = sc;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready got 0, want 1");
      end else begin
         q.push_back({e1, e2});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(name, 32'(q.size()), 32'd0);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer, checks stall stability.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (hold_v && out_valid) begin
            chk("stall_out1", 32'(out1), 32'(hold_o1));
            chk("stall_out2", 32'(out2), 32'(hold_o2));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got %h/%h, want none", out1, out2);
            end else begin
               mon_e = q.pop_front();
               chk("out1", 32'(out1), 32'(mon_e.o1));
               chk("out2", 32'(out2), 32'(mon_e.o2));
            end
         end
         hold_v  = out_valid && !out_ready;
         hold_o1 = out1;
         hold_o2 = out2;
      end else begin
         hold_v = 1'b0;
      end
   end

   always @(posedge clk) begin
      #2;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      exp_t e;
`ifdef BFU_SAT_EN
      e2_re = 8'd127;
      e3_re = 8'h80;
`else
      e2_re = 8'hc7;  // -57
      e3_re = 8'h00;
`endif
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out1", 32'(out1), 32'd0);
      chk("rst_out2", 32'(out2), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;

      // 1: basic, with latency
      send(64, 0, 64, 0, 127, 0, 1'b1, pk(63, 0), pk(0, 0));
      wait_valid(lat);
      chk("latency_t1", 32'(lat), 32'd3);
      drain("drain_t1");
      chk("ovf_t1", 32'(ovf), 32'd0);

      // 2: overflow, then clear
      send(100, 0, 100, 0, 127, 0, 1'b0, {e2_re, 8'd0}, pk(0, 0));
      drain("drain_t2");
      chk("ovf_t2_set", 32'(ovf), 32'd1);
      clr_pulse();
      chk("ovf_t2_clr", 32'(ovf), 32'd0);

      // 3: -1.0 twiddle corner, scaled then unscaled
      send(-128, 0, -128, 0, -128, 0, 1'b1, pk(0, 0), pk(-128, 0));
      drain("drain_t3a");
      chk("ovf_t3a", 32'(ovf), 32'd0);
      send(-128, 0, -128, 0, -128, 0, 1'b0, pk(0, 0), {e3_re, 8'd0});
      drain("drain_t3b");
      chk("ovf_t3b", 32'(ovf), 32'd1);
      clr_pulse();

      // 4: imaginary path
      send(0, 0, 0, 64, 0, 127, 1'b1, pk(-32, 0), pk(31, 0));
      drain("drain_t4");
      chk("ovf_t4", 32'(ovf), 32'd0);

      // scale travels with its sample: back-to-back differing scale
      send(-128, 0, -128, 0, -128, 0, 1'b1, pk(0, 0), pk(-128, 0));
      send(64, 0, 64, 0, 127, 0, 1'b0, pk(127, 0), pk(0, 0));
      drain("drain_mixscale");
      clr_pulse();

      // set beats clear in the same cycle
      clr_ovf = 1'b1;
      send(100, 0, 100, 0, 127, 0, 1'b0, {e2_re, 8'd0}, pk(0, 0));
      wait_valid(lat);
      chk("ovf_set_wins", 32'(ovf), 32'd1);
      @(negedge clk);
      #1;
      chk("ovf_clr_after", 32'(ovf), 32'd0);
      clr_ovf = 1'b0;
      drain("drain_setwins");

      // 5: 16 back-to-back pairs with random backpressure
      rnd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = model(i * 7 - 50, 20 - i * 5, i * 3, 10 - i * 4, 100 - 13 * i, -60 + 9 * i,
                   1'(i % 2));
         send(i * 7 - 50, 20 - i * 5, i * 3, 10 - i * 4, 100 - 13 * i, -60 + 9 * i,
              1'(i % 2), e.o1, e.o2);
      end
      drain("drain_t5");
      rnd_en = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      clr_pulse();

      // 6: async reset with samples in flight
      send(100, 0, 100, 0, 127, 0, 1'b0, {e2_re, 8'd0}, pk(0, 0));
      drain("drain_t6pre");
      chk("ovf_t6pre", 32'(ovf), 32'd1);
      for (int i = 0; i < 3; i++) send(64, 0, 64, 0, 127, 0, 1'b1, pk(63, 0), pk(0, 0));
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out1", 32'(out1), 32'd0);
      chk("arst_out2", 32'(out2), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(0, 0, 0, 64, 0, 127, 1'b1, pk(-32, 0), pk(31, 0));
      wait_valid(lat);
      chk("latency_t6", 32'(lat), 32'd3);
      drain("drain_t6");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
